// File: rtl/inst_fetch.sv
// Gumnut instruction fetch: PC register, single-beat instruction reads,
// hold/stall and redirect handling. Optional timeout under FETCH_TIMEOUT_EN.
module inst_fetch #(
    parameter logic [11:0] RESET_PC       = 12'h000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        inst_cyc_o,
    output logic        inst_stb_o,
    output logic [11:0] inst_adr_o,
    input  logic [17:0] inst_dat_i,
    input  logic        inst_ack_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [11:0] redirect_addr_i,
    output logic [17:0] inst_o,
    output logic        valid_o,
    output logic [11:0] pc_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [11:0] pc_q;
    logic [11:0] pc_d;
    logic [17:0] inst_q;
    logic [11:0] pc_o_q;
    logic        capture;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_cfg
        $error("inst_fetch: TIMEOUT_CYCLES out of range 2..255");
    end

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] tmo_cnt_q;
    logic       tmo_q;
    logic       tmo_hit;
`endif

    // Next-state, next-PC and capture decisions; redirect always wins
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        capture = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        tmo_hit = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (redirect_i) begin
                    pc_d = redirect_addr_i;
                end
            end
            FETCH: begin
                if (redirect_i) begin
                    pc_d = redirect_addr_i;
                end else if (inst_ack_i) begin
                    capture = 1'b1;
                    pc_d    = pc_q + 12'd1;
                    state_d = HOLD;
                end else begin
`ifdef FETCH_TIMEOUT_EN
                    if (tmo_cnt_q == TMO_LAST) begin
                        tmo_hit = 1'b1;
                        state_d = IDLE;
                    end
`endif
                end
            end
            HOLD: begin
                if (redirect_i) begin
                    pc_d    = redirect_addr_i;
                    state_d = FETCH;
                end else if (!stall_i) begin
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, PC and captured instruction registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            pc_o_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (capture) begin
                inst_q <= inst_dat_i;
                pc_o_q <= pc_q;
            end
        end
    end

`ifdef FETCH_TIMEOUT_EN
    // Count consecutive unacked FETCH cycles; restart on FETCH entry or redirect
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            tmo_q <= tmo_hit;
            if (redirect_i || (state_d == FETCH && state_q != FETCH)) begin
                tmo_cnt_q <= '0;
            end else if (state_q == FETCH && !inst_ack_i) begin
                tmo_cnt_q <= tmo_cnt_q + 8'd1;
            end
        end
    end

    assign timeout_o = tmo_q;
`else
    assign timeout_o = 1'b0;
`endif

    assign inst_cyc_o = (state_q == FETCH);
    assign inst_stb_o = (state_q == FETCH);
    assign inst_adr_o = pc_q;
    assign valid_o    = (state_q == HOLD);
    assign inst_o     = inst_q;
    assign pc_o       = pc_o_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: per-cycle bus checks plus a scoreboard of
// delivered {inst, pc} pairs popped by a monitor on each consumption.
module tb_inst_fetch;

`ifdef FETCH_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        inst_cyc_o;
    logic        inst_stb_o;
    logic [11:0] inst_adr_o;
    logic [17:0] inst_dat_i;
    logic        inst_ack_i;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [11:0] redirect_addr_i = 12'h000;
    logic [17:0] inst_o;
    logic        valid_o;
    logic [11:0] pc_o;
    logic        timeout_o;

    logic        ack_en = 1'b0;
    int          total = 0;
    int          bad = 0;
    logic [29:0] sb_q[$];

    inst_fetch #(
        .RESET_PC      (12'h000),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .inst_cyc_o     (inst_cyc_o),
        .inst_stb_o     (inst_stb_o),
        .inst_adr_o     (inst_adr_o),
        .inst_dat_i     (inst_dat_i),
        .inst_ack_i     (inst_ack_i),
        .stall_i        (stall_i),
        .redirect_i     (redirect_i),
        .redirect_addr_i(redirect_addr_i),
        .inst_o         (inst_o),
        .valid_o        (valid_o),
        .pc_o           (pc_o),
        .timeout_o      (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    // memory returns address + 0x100, acking while enabled
    assign inst_dat_i = 18'(inst_adr_o) + 18'h100;
    assign inst_ack_i = ack_en & inst_cyc_o;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: each accepted instruction must match the next scoreboard entry
    always @(negedge clk_i) begin
        if (!rst_i && valid_o && !stall_i && !redirect_i) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                logic [29:0] e;
                e = sb_q.pop_front();
                chk("sb_inst", int'(inst_o), int'(e[29:12]));
                chk("sb_pc", int'(pc_o), int'(e[11:0]));
            end
        end
    end

    // Drive one cycle of inputs, check Moore outputs mid-cycle, advance
    task automatic step(input logic r, input logic a, input logic s,
                        input logic rd, input logic [11:0] ra,
                        input logic ecyc, input logic [11:0] eadr,
                        input logic eval, input logic etmo,
                        input logic sb);
        rst_i           = r;
        ack_en          = a;
        stall_i         = s;
        redirect_i      = rd;
        redirect_addr_i = ra;
        @(negedge clk_i);
        chk("cyc", int'(inst_cyc_o), int'(ecyc));
        chk("stb", int'(inst_stb_o), int'(ecyc));
        chk("adr", int'(inst_adr_o), int'(eadr));
        chk("valid", int'(valid_o), int'(eval));
        chk("timeout", int'(timeout_o), int'(etmo));
        if (sb) begin
            sb_q.push_back({18'(eadr) + 18'h100, eadr});
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_inst", int'(inst_o), 0);
        chk("rst_pc_o", int'(pc_o), 0);
        //   rst ack stl red raddr    cyc adr     val tmo sb
        step(1, 0, 0, 0, 12'h000, 0, 12'h000, 0, 0, 0);
        step(0, 0, 0, 0, 12'h000, 0, 12'h000, 0, 0, 0);
        step(0, 1, 0, 0, 12'h000, 1, 12'h000, 0, 0, 1);
        step(0, 1, 0, 0, 12'h000, 0, 12'h001, 1, 0, 0);
        step(0, 1, 0, 0, 12'h000, 1, 12'h001, 0, 0, 1);
        step(0, 1, 0, 0, 12'h000, 0, 12'h002, 1, 0, 0);
        step(0, 1, 0, 0, 12'h000, 1, 12'h002, 0, 0, 1);
        step(0, 1, 0, 0, 12'h000, 0, 12'h003, 1, 0, 0);
        step(0, 1, 0, 0, 12'h000, 1, 12'h003, 0, 0, 1);
        step(0, 1, 0, 0, 12'h000, 0, 12'h004, 1, 0, 0);
        step(0, 1, 0, 0, 12'h000, 1, 12'h004, 0, 0, 1);
        step(0, 0, 0, 0, 12'h000, 0, 12'h005, 1, 0, 0);
        // ack delayed three cycles at 005
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 12'h000, 1, 12'h005, 0, 0, 0);
        end
        step(0, 1, 0, 0, 12'h000, 1, 12'h005, 0, 0, 1);
        // five stalled cycles, no bus activity
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 0, 12'h000, 0, 12'h006, 1, 0, 0);
            chk("stall_inst", int'(inst_o), 'h105);
            chk("stall_pc_o", int'(pc_o), 'h005);
        end
        step(0, 0, 0, 0, 12'h000, 0, 12'h006, 1, 0, 0);
        // redirect in FETCH, then redirect colliding with ack
        step(0, 0, 0, 1, 12'h010, 1, 12'h006, 0, 0, 0);
        step(0, 1, 0, 1, 12'h3A0, 1, 12'h010, 0, 0, 0);
        step(0, 1, 0, 0, 12'h000, 1, 12'h3A0, 0, 0, 1);
        step(0, 1, 0, 0, 12'h000, 0, 12'h3A1, 1, 0, 0);
        // jump to FFF and check the wrap
        step(0, 1, 0, 1, 12'hFFF, 1, 12'h3A1, 0, 0, 0);
        step(0, 1, 0, 0, 12'h000, 1, 12'hFFF, 0, 0, 1);
        step(0, 1, 0, 0, 12'h000, 0, 12'h000, 1, 0, 0);
        step(0, 1, 0, 0, 12'h000, 1, 12'h000, 0, 0, 0);
        // redirect beats stall in HOLD; held 000 word dropped
        step(0, 0, 1, 1, 12'h020, 0, 12'h001, 1, 0, 0);
        // no ack at 020: timeout retries when enabled, waits forever otherwise
        for (int k = 0; k < 120; k++) begin
            logic hit;
            hit = TMO_EN && (k % 17 == 16);
            step(0, 0, 0, 0, 12'h000, !hit, 12'h020, 0, hit, 0);
        end
        step(0, 1, 0, 0, 12'h000, 1, 12'h020, 0, 0, 0);
        // reset during HOLD drops the word and refetches from RESET_PC
        step(1, 0, 1, 0, 12'h000, 0, 12'h021, 1, 0, 0);
        step(0, 0, 0, 0, 12'h000, 0, 12'h000, 0, 0, 0);
        chk("rst2_inst", int'(inst_o), 0);
        chk("rst2_pc_o", int'(pc_o), 0);
        step(0, 1, 0, 0, 12'h000, 1, 12'h000, 0, 0, 1);
        step(0, 0, 0, 0, 12'h000, 0, 12'h001, 1, 0, 0);
        step(0, 0, 0, 0, 12'h000, 1, 12'h001, 0, 0, 0);
        chk("sb_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage for the Gumnut core. It holds the 12-bit program counter and runs single-beat Wishbone-style reads from instruction memory. It captures each 18-bit instruction word and presents it, with its address, to the IR decode stage. It also honours downstream stall and branch/jump redirect requests.

## Interface

Parameters:
- RESET_PC, 12'h000, PC value loaded on reset.
- TIMEOUT_CYCLES, 16, number of consecutive unacknowledged FETCH cycles before a timeout. Used only with FETCH_TIMEOUT_EN. Legal range 2..255.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- inst_cyc_o  out  1  bus cycle in progress.
- inst_stb_o  out  1  strobe; always equal to inst_cyc_o.
- inst_adr_o  out  12  word address; always equal to the current PC register.
- inst_dat_i  in  18  instruction read data; valid when inst_ack_i=1.
- inst_ack_i  in  1  memory acknowledge.
- stall_i  in  1  downstream not ready; the consumer accepts on a cycle with valid_o=1 and stall_i=0.
- redirect_i  in  1  load PC from redirect_addr_i (branch/jump/reti).
- redirect_addr_i  in  12  redirect target.
- inst_o  out  18  captured instruction word; feeds IR inst_i.
- valid_o  out  1  inst_o/pc_o hold a valid, unconsumed instruction.
- pc_o  out  12  address that inst_o was fetched from.
- timeout_o  out  1  one-cycle pulse on fetch timeout; constant 0 without FETCH_TIMEOUT_EN.

## Operation

- FSM states: IDLE, FETCH, HOLD. Outputs are Moore:
  - inst_cyc_o = inst_stb_o = (state==FETCH).
  - valid_o = 1 in HOLD only.
- Reset (rst_i=1 at an edge, in any state):
  - state<=IDLE, pc<=RESET_PC.
  - inst_o<=0, pc_o<=0, valid_o=0, cyc/stb=0, timeout_o<=0.
  - An outstanding bus cycle is abandoned; a late ack is ignored, because ack is only sampled in FETCH.
- IDLE:
  - If redirect_i: pc<=redirect_addr_i.
  - Always go to FETCH next cycle.
- FETCH (priority in this order):
  - If redirect_i: pc<=redirect_addr_i, stay in FETCH. Any ack in the same cycle is discarded and inst_o is not updated.
  - Else if inst_ack_i: inst_o<=inst_dat_i, pc_o<=pc, pc<=pc+1 mod 4096, go to HOLD.
  - Else: stay in FETCH, hold the address.
- HOLD (priority in this order):
  - If redirect_i: pc<=redirect_addr_i, go to FETCH. The held instruction is dropped.
  - Else if stall_i=0: the instruction is consumed, go to FETCH.
  - Else: stay in HOLD; inst_o and pc_o stay stable.
- PC arithmetic: 12-bit unsigned; 12'hFFF+1 wraps to 12'h000 silently.
- inst_o and pc_o keep their last value after consumption. Only valid_o qualifies them.

## Timing

- Zero-wait memory (ack in the same cycle as stb): FETCH and HOLD alternate, giving one instruction every 2 cycles.
- Ack at edge N in FETCH: valid_o=1 and inst_o updated in cycle N+1.
- Consumption at edge M in HOLD: inst_cyc_o=1 with the new PC in cycle M+1.
- Redirect at edge R in FETCH, HOLD or IDLE: inst_adr_o=redirect_addr_i in cycle R+1, with cyc=1.
- First bus cycle after reset: the cycle after the first edge with rst_i=0 (one IDLE cycle). inst_adr_o=RESET_PC.
- Simultaneous redirect and ack: redirect wins.
- Simultaneous redirect and stall in HOLD: redirect wins.

## Configuration

- FETCH_TIMEOUT_EN defined:
  - An 8-bit counter clears on every entry to FETCH, on redirect, and on reset.
  - It increments on each FETCH cycle without ack.
  - When TIMEOUT_CYCLES consecutive FETCH cycles pass without ack:
    - timeout_o pulses high for one cycle.
    - The FSM goes to IDLE, dropping cyc for one cycle.
    - The fetch is retried at the same, unchanged pc.
- FETCH_TIMEOUT_EN undefined:
  - No counter is built; timeout_o is tied to 0.
  - FETCH waits for ack indefinitely.

## Test plan

- Reset release, zero-wait memory returning word = address+18'h100 → inst_adr_o sequence 000,001,002. inst_o 18'h100,18'h101,18'h102 with pc_o 000,001,002. valid_o toggles 1 on every other cycle.
- Ack delayed 3 cycles at pc=005 → cyc/stb/adr=005 held for 4 cycles. valid_o rises the cycle after ack with pc_o=005.
- stall_i held 5 cycles while valid_o=1 → inst_o and pc_o unchanged, no cyc during the stall. Fetch of pc+1 starts the cycle after stall_i falls.
- redirect_i with addr 12'h3A0, asserted together with ack during FETCH of 010 → ack data discarded and valid_o stays 0. Next adr=3A0; first delivered pc_o=3A0.
- pc=FFF fetched → pc_o=FFF, next inst_adr_o=000. Separately, rst_i pulsed during HOLD → valid_o=0 and cyc=0 next cycle, then refetch from RESET_PC.
- With FETCH_TIMEOUT_EN and TIMEOUT_CYCLES=16, ack never asserted at pc=020 → timeout_o single pulse after 16 FETCH cycles, one IDLE cycle, retry at adr=020. Without the macro, timeout_o stays 0 for 100+ cycles.
